ps2_scan_ctrl: RTL and testbench
================================

// Module: ps2_scan_ctrl
// PURPOSE
//  Sequences raw PS/2 bytes from the keyboard receiver into key events for the typewriter logic.
//  - Decodes the E0 (extended) and F0 (break) prefixes.
//  - Skips the E1 pause sequence and filters keyboard status codes.
//  - Buffers events in a FIFO with a valid/ready output.
//  Sits between the keyboard receiver (already synchronised to clk) and the character/display path.
// PARAMETERS
//  FIFO_DEPTH  8     event FIFO entries; power of 2, >= 2
//  TIMEOUT     2048  clk cycles allowed between a prefix byte and its follow-up byte
//  ERR_W       8     width of the saturating error counters
// PORTS
//  clk         in   1           system clock
//  rst         in   1           asynchronous reset, active-high
//  byte_in     in   8           received scan byte
//  byte_vld    in   1           one-cycle strobe; byte_in is valid in this cycle
//  byte_perr   in   1           parity error for the byte_vld strobe in the same cycle
//  ev_code     out  8           key scan code (prefixes stripped)
//  ev_ext      out  1           1 = extended key (E0 prefix seen)
//  ev_rel      out  1           1 = release (F0 prefix seen); 0 = press
//  ev_valid    out  1           FIFO not empty
//  ev_ready    in   1           consumer accepts the head event when ev_valid is also 1
//  perr_cnt    out  ERR_W       saturating count of parity-errored bytes
//  ovf_cnt     out  ERR_W       saturating count of events dropped because the FIFO was full
//  tmo_cnt     out  ERR_W       saturating count of prefix timeouts
// BEHAVIOUR
//  Reset:
//   - All outputs, counters and FIFO pointers are 0; FSM enters IDLE.
//   - Reset mid-sequence discards any partial prefix and all FIFO contents.
//  FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 F0 seen), SKIP (E1 seen).
//   - IDLE:
//     - E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip counter = 7.
//     - AA, FA, FE, EE, 00, FF: no event, stay in IDLE.
//     - Any other byte: push {code, ext=0, rel=0}.
//   - EXT: F0 -> EXTBRK; any other byte: push {code, 1, 0} -> IDLE.
//   - BRK: push {code, 0, 1} -> IDLE.
//   - EXTBRK: push {code, 1, 1} -> IDLE.
//   - SKIP: each byte_vld decrements the skip counter; -> IDLE after the 7th byte; no event.
//  Bytes flagged byte_perr:
//   - Byte is discarded; perr_cnt increments.
//   - FSM returns to IDLE from any state, including SKIP.
//  Timeout:
//   - Counter runs while the FSM is in EXT, BRK, EXTBRK or SKIP; it is cleared on every byte_vld.
//   - Reaching TIMEOUT-1 -> IDLE and tmo_cnt increments; no event.
//  Latency: event is written on the clk edge that samples byte_vld; ev_valid rises the next cycle.
//  FIFO and handshake:
//   - Pop happens when ev_valid & ev_ready; the head is held stable while ev_ready is 0.
//   - Push and pop in the same cycle are both performed, including when the FIFO is full.
//   - Push while full with no pop: event dropped, ovf_cnt increments, FIFO contents unchanged.
//   - Pop while empty has no effect.
//   - Pointers wrap modulo FIFO_DEPTH; a separate count register distinguishes full from empty.
//  Counters saturate at 2**ERR_W-1 and do not wrap.
// CONFIGURATION
//  PS2_SHIFT_TRACK_EN defined:
//   - Adds output ev_shift (1 bit), stored with each FIFO entry.
//   - Internal flags track left shift (12) and right shift (59) press/release; non-extended only.
//   - ev_shift = (lshift | rshift), sampled before the current event updates the flags.
//   - Both flags clear on reset and on a parity error.
//  PS2_SHIFT_TRACK_EN undefined: no ev_shift port, no shift flags; FIFO entry is 10 bits.
// TESTING
//  - Bytes 1C with ev_ready=1 -> one event {1C,ext0,rel0}, ev_valid high for exactly 1 cycle.
//  - F0,1C then E0,F0,75 -> events {1C,0,1} then {75,1,1}, in that order.
//  - E1 plus 7 pause bytes, then 1C -> exactly one event {1C,0,0}.
//  - E0, then no byte for TIMEOUT cycles, then 1C -> tmo_cnt=1, event {1C,0,0}.
//  - ev_ready=0, push FIFO_DEPTH+2 codes -> first 8 retained in order, ovf_cnt=2;
//    simultaneous push and pop when full -> no drop.
//  - F0 with byte_perr=1, then 1C -> perr_cnt=1, event {1C,0,0} (press); assert rst mid-E0 -> all outputs 0.

Source files
------------

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scan-byte sequencer: strips E0/F0 prefixes, skips E1 pause bytes, filters status codes,
// and queues key events in a FIFO with valid/ready output. Optional PS2_SHIFT_TRACK_EN adds ev_shift.
module ps2_scan_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 2048,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_vld,
    input  logic             byte_perr,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_rel,
`ifdef PS2_SHIFT_TRACK_EN
    output logic             ev_shift,
`endif
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [ERR_W-1:0] perr_cnt,
    output logic [ERR_W-1:0] ovf_cnt,
    output logic [ERR_W-1:0] tmo_cnt
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);
`ifdef PS2_SHIFT_TRACK_EN
    localparam int EW = 11;
`else
    localparam int EW = 10;
`endif

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          byte_ok, perr_evt, tmo_fire, ignore_idle;
    logic          push, push_ext, push_rel;
    logic [EW-1:0] ent_in;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    logic          full, pop, wr_en;

    assign byte_ok     = byte_vld & ~byte_perr;
    assign perr_evt    = byte_vld & byte_perr;
    assign tmo_fire    = ~byte_vld & (state_q != S_IDLE) & (tmo_q == TW'(TIMEOUT - 1));
    // Prefixes and keyboard status replies never produce an event from IDLE.
    assign ignore_idle = byte_in inside {8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (perr_evt || tmo_fire) begin
            state_d = S_IDLE;
        end else if (byte_ok) begin
            case (state_q)
                S_IDLE: begin
                    case (byte_in)
                        8'hE0:   state_d = S_EXT;
                        8'hF0:   state_d = S_BRK;
                        8'hE1: begin
                            state_d = S_SKIP;
                            skip_d  = 3'd7;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
                S_EXT:   state_d = (byte_in == 8'hF0) ? S_EXTBRK : S_IDLE;
                S_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (byte_vld || state_q == S_IDLE || tmo_fire) tmo_d = '0;
        else                                           tmo_d = tmo_q + 1'b1;
    end

    always_comb begin
        push     = 1'b0;
        push_ext = 1'b0;
        push_rel = 1'b0;
        if (byte_ok) begin
            case (state_q)
                S_IDLE:   push = ~ignore_idle;
                S_EXT: begin
                    push     = (byte_in != 8'hF0);
                    push_ext = 1'b1;
                end
                S_BRK: begin
                    push     = 1'b1;
                    push_rel = 1'b1;
                end
                S_EXTBRK: begin
                    push     = 1'b1;
                    push_ext = 1'b1;
                    push_rel = 1'b1;
                end
                default:  push = 1'b0;
            endcase
        end
    end

`ifdef PS2_SHIFT_TRACK_EN
    logic lsh_q, rsh_q;

    // Flags follow the key even when its event is dropped on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lsh_q <= 1'b0;
            rsh_q <= 1'b0;
        end else if (perr_evt) begin
            lsh_q <= 1'b0;
            rsh_q <= 1'b0;
        end else if (push && !push_ext) begin
            if (byte_in == 8'h12) lsh_q <= ~push_rel;
            if (byte_in == 8'h59) rsh_q <= ~push_rel;
        end
    end

    assign ent_in   = {lsh_q | rsh_q, push_ext, push_rel, byte_in};
    assign ev_shift = mem_q[rd_q][10];
`else
    assign ent_in   = {push_ext, push_rel, byte_in};
`endif

    assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign ev_valid = (cnt_q != '0);
    assign pop      = ev_valid & ev_ready;
    assign wr_en    = push & (~full | pop);
    assign {ev_ext, ev_rel, ev_code} = mem_q[rd_q][9:0];

    // When full, the write slot equals the head slot being popped this same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_q] <= ent_in;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (wr_en && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!wr_en && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_cnt <= '0;
            ovf_cnt  <= '0;
            tmo_cnt  <= '0;
        end else begin
            if (perr_evt && perr_cnt != '1)                 perr_cnt <= perr_cnt + 1'b1;
            if (push && full && !pop && ovf_cnt != '1)      ovf_cnt  <= ovf_cnt + 1'b1;
            if (tmo_fire && tmo_cnt != '1)                  tmo_cnt  <= tmo_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Randomized + directed bench for ps2_scan_ctrl with a prefix-list reference model and event scoreboard.
module tb_ps2_scan_ctrl;
    localparam int DEPTH = 8;
    localparam int TMO   = 2048;
    localparam int EW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_vld = 1'b0;
    logic          byte_perr = 1'b0;
    logic          ev_ready = 1'b0;
    logic [7:0]    ev_code;
    logic          ev_ext, ev_rel, ev_valid;
    logic [EW-1:0] perr_cnt, ovf_cnt, tmo_cnt;

    ps2_scan_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .ERR_W(EW)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_vld(byte_vld), .byte_perr(byte_perr),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_rel(ev_rel), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .perr_cnt(perr_cnt), .ovf_cnt(ovf_cnt), .tmo_cnt(tmo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pfx[$];
    int skip_left, idle_run, occ, m_perr, m_ovf, m_tmo;
    int checks = 0, errors = 0, vld_cyc = 0;
    logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00,
                              8'hFF, 8'h12, 8'h59, 8'h1C, 8'h75, 8'h14, 8'h77, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit has_pfx(input logic [7:0] b);
        foreach (pfx[i]) if (pfx[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_status(input logic [7:0] b);
        return (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF);
    endfunction

    function automatic void model_clear();
        pfx.delete();
        exp_q.delete();
        skip_left = 0; idle_run = 0; occ = 0;
        m_perr = 0; m_ovf = 0; m_tmo = 0;
    endfunction

    // Drive one cycle; the model is advanced right after the edge that samples these inputs.
    task automatic cyc(input bit v, input logic [7:0] b, input bit p, input bit r);
        bit  pushed, pop;
        ev_t ev;
        byte_vld = v; byte_in = b; byte_perr = p; ev_ready = r;
        @(posedge clk);
        pushed = 1'b0;
        ev     = '0;
        if (v) begin
            idle_run = 0;
            if (p) begin
                if (m_perr < 255) m_perr++;
                pfx.delete();
                skip_left = 0;
            end else if (skip_left > 0) begin
                skip_left--;
            end else if (pfx.size() == 0 && b == 8'hE0) begin
                pfx.push_back(b);
            end else if (b == 8'hF0 && (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0))) begin
                pfx.push_back(b);
            end else if (pfx.size() == 0 && b == 8'hE1) begin
                skip_left = 7;
            end else if (!(pfx.size() == 0 && is_status(b))) begin
                ev.code = b;
                ev.ext  = has_pfx(8'hE0);
                ev.rel  = has_pfx(8'hF0);
                pushed  = 1'b1;
                pfx.delete();
            end
        end else begin
            if (idle_run < TMO) idle_run++;
            if ((pfx.size() != 0 || skip_left != 0) && idle_run == TMO) begin
                if (m_tmo < 255) m_tmo++;
                pfx.delete();
                skip_left = 0;
            end
        end
        pop = r && (occ > 0);
        if (pushed) begin
            if (occ < DEPTH || pop) begin
                exp_q.push_back(ev);
                occ++;
            end else if (m_ovf < 255) begin
                m_ovf++;
            end
        end
        if (pop) occ--;
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, r);
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst) begin
            if (ev_valid) vld_cyc++;
            chk("ev_valid_vs_model", ev_valid, occ > 0);
            if (ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event actual=%0h/%0b/%0b expected=none", ev_code, ev_ext, ev_rel);
                end else begin
                    e = exp_q.pop_front();
                    chk("ev_code", ev_code, e.code);
                    chk("ev_ext", ev_ext, e.ext);
                    chk("ev_rel", ev_rel, e.rel);
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_code", ev_code, 0);
        chk("rst_ev_ext", ev_ext, 0);
        chk("rst_ev_rel", ev_rel, 0);
        chk("rst_perr_cnt", perr_cnt, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_tmo_cnt", tmo_cnt, 0);
        rst = 1'b0;
        idle(2, 1'b1);

        vld_cyc = 0;
        cyc(1'b1, 8'h1C, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("single_valid_cycles", vld_cyc, 1);

        cyc(1'b1, 8'hF0, 1'b0, 1'b1);
        cyc(1'b1, 8'h1C, 1'b0, 1'b1);
        cyc(1'b1, 8'hE0, 1'b0, 1'b1);
        cyc(1'b1, 8'hF0, 1'b0, 1'b1);
        cyc(1'b1, 8'h75, 1'b0, 1'b1);
        idle(4, 1'b1);

        vld_cyc = 0;
        cyc(1'b1, 8'hE1, 1'b0, 1'b1);
        cyc(1'b1, 8'h14, 1'b0, 1'b1);
        cyc(1'b1, 8'h77, 1'b0, 1'b1);
        cyc(1'b1, 8'hE1, 1'b0, 1'b1);
        cyc(1'b1, 8'hF0, 1'b0, 1'b1);
        cyc(1'b1, 8'h14, 1'b0, 1'b1);
        cyc(1'b1, 8'hF0, 1'b0, 1'b1);
        cyc(1'b1, 8'h77, 1'b0, 1'b1);
        cyc(1'b1, 8'h1C, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("pause_one_event", vld_cyc, 1);

        cyc(1'b1, 8'hE0, 1'b0, 1'b1);
        idle(TMO + 5, 1'b1);
        cyc(1'b1, 8'h1C, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("tmo_cnt_after_timeout", tmo_cnt, 1);

        for (int i = 0; i < DEPTH + 2; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("ovf_cnt_after_fill", ovf_cnt, 2);
        cyc(1'b1, 8'h2A, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("ovf_cnt_push_pop_full", ovf_cnt, 2);
        idle(DEPTH + 4, 1'b1);

        cyc(1'b1, 8'hF0, 1'b1, 1'b1);
        cyc(1'b1, 8'h1C, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("perr_cnt_after_perr", perr_cnt, 1);

        cyc(1'b1, 8'h1C, 1'b0, 1'b0);
        cyc(1'b1, 8'hE0, 1'b0, 1'b0);
        rst = 1'b1;
        byte_vld = 1'b0;
        model_clear();
        #2;
        chk("midrst_ev_valid", ev_valid, 0);
        chk("midrst_ev_code", ev_code, 0);
        chk("midrst_perr_cnt", perr_cnt, 0);
        chk("midrst_ovf_cnt", ovf_cnt, 0);
        chk("midrst_tmo_cnt", tmo_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 8'h1C, 1'b0, 1'b1);
        idle(4, 1'b1);
        chk("midrst_followup_consumed", exp_q.size(), 0);

        for (int n = 0; n < 2500; n++) begin
            logic [7:0] b;
            b = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
            cyc(1'b1, b, ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 499) == 0) gap = TMO + 3;
            idle(gap, ($urandom_range(0, 9) < 7));
        end

        for (int k = 0; k < 50 && occ > 0; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        idle(2, 1'b1);
        chk("final_drained", exp_q.size(), 0);
        chk("final_ev_valid", ev_valid, 0);
        chk("final_perr_cnt", perr_cnt, m_perr);
        chk("final_ovf_cnt", ovf_cnt, m_ovf);
        chk("final_tmo_cnt", tmo_cnt, m_tmo);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
